pic_cycle_sequencer: RTL



---
 rtl/pic_cycle_sequencer_pkg.sv | 35 +++
 rtl/pic_cycle_sequencer.sv | 82 ++++++++
 2 files changed

// File: rtl/pic_cycle_sequencer_pkg.sv
// Shared sequencer definitions: fetch/execute phase codes, sequencer modes and the NOP opcode used on flush.
// The phase codes are decoded directly by the IR, PC and ALU stages.
package pic_cycle_sequencer_pkg;

  localparam int FE_STATE_BITS = 3;
  localparam int EX_STATE_BITS = 3;

  localparam logic [FE_STATE_BITS-1:0] FE_IDLE = 3'd0;
  localparam logic [FE_STATE_BITS-1:0] FE_Q1   = 3'd1;
  localparam logic [FE_STATE_BITS-1:0] FE_Q2   = 3'd2;
  localparam logic [FE_STATE_BITS-1:0] FE_Q3   = 3'd3;
  localparam logic [FE_STATE_BITS-1:0] FE_Q4   = 3'd4;

  localparam logic [EX_STATE_BITS-1:0] EX_IDLE = 3'd0;
  localparam logic [EX_STATE_BITS-1:0] EX_Q1   = 3'd1;
  localparam logic [EX_STATE_BITS-1:0] EX_Q2   = 3'd2;
  localparam logic [EX_STATE_BITS-1:0] EX_Q3   = 3'd3;
  localparam logic [EX_STATE_BITS-1:0] EX_Q4   = 3'd4;

  localparam logic [11:0] I_NOP_12 = 12'h000;

  // SEQ_RESET is the parked state right after reset; SEQ_RUN is the primed pipeline.
  typedef enum logic [1:0] {
    SEQ_RESET = 2'd0,
    SEQ_FILL  = 2'd1,
    SEQ_RUN   = 2'd2,
    SEQ_SLEEP = 2'd3
  } seq_mode_e;

  // Q1..Q4 codes are the 2-bit phase plus one.
  function automatic logic [2:0] phase_code(input logic [1:0] ph);
    return {1'b0, ph} + 3'd1;
  endfunction

endpackage

// File: rtl/pic_cycle_sequencer.sv
// Q1-Q4 instruction-cycle sequencer: fill after reset/wake, lockstep run, goto/skip flush, SLEEP/wake.
// Latency: first FE_Q1 one clk after reset release, first EX_Q1 4 clk later; ce=0 freezes all state.
module pic_cycle_sequencer
  import pic_cycle_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter bit SLEEP_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     goto,
  input  logic                     skip,
  input  logic                     sleepReq,
  input  logic                     wake,
  output logic [FE_STATE_BITS-1:0] fetchState,
  output logic [EX_STATE_BITS-1:0] executeState,
  output logic                     flush,
  output logic                     sleeping,
  output logic [CNT_WIDTH-1:0]     instCount
);

  seq_mode_e            mode_q, mode_d;
  logic [1:0]           phase_q, phase_d;
  logic                 flush_q, flush_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 at_q4;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= SEQ_RESET;
      phase_q <= 2'd0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else if (ce) begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q + 2'd1;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    at_q4   = (phase_q == 2'd3);
    unique case (mode_q)
      SEQ_RESET: begin
        mode_d  = SEQ_FILL;
        phase_d = 2'd0;
      end
      SEQ_FILL: begin
        if (at_q4) mode_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (at_q4) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          // A pending wake cancels SLEEP; SLEEP entry drops any goto/skip flush.
          if (SLEEP_EN && sleepReq && !wake) begin
            mode_d  = SEQ_SLEEP;
            phase_d = 2'd0;
          end else begin
            flush_d = goto | skip;
          end
        end
      end
      SEQ_SLEEP: begin
        phase_d = 2'd0;
        if (wake) mode_d = SEQ_FILL;
      end
    endcase
  end

  assign fetchState   = (mode_q == SEQ_FILL || mode_q == SEQ_RUN) ? phase_code(phase_q) : FE_IDLE;
  assign executeState = (mode_q == SEQ_RUN) ? phase_code(phase_q) : EX_IDLE;
  assign flush        = flush_q;
  assign sleeping     = (mode_q == SEQ_SLEEP);
  assign instCount    = cnt_q;

endmodule
